// File: rtl/bridge_softstart_sequencer.sv
// Soft-start sequencer for the H-bridge half-period: ramps o_period toward a clamped target and latches OV/OC faults.
// Latency: every output is registered, and any decision appears on the next edge. No backpressure; the ramp advances one step per STEP_DIV cycles.
// Optional soft stop is enabled by defining BRIDGE_SOFT_STOP_EN. When it is undefined, a disable goes straight to IDLE.
module bridge_softstart_sequencer #(
    parameter int unsigned PERIOD_START = 500,
    parameter int unsigned PERIOD_MIN   = 50,
    parameter int unsigned PERIOD_STEP  = 1,
    parameter int unsigned STEP_DIV     = 100000,
    parameter logic [7:0]  OV_LIMIT     = 8'd160,
    parameter logic [7:0]  OC_LIMIT     = 8'd200
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [31:0] i_target_period,
    input  logic [7:0]  i_vbat,
    input  logic [7:0]  i_ibat,
    input  logic        i_sample_valid,
    input  logic        i_fault_clear,
    output logic [31:0] o_period,
    output logic        o_bridge_en,
    output logic [2:0]  o_state,
    output logic        o_fault,
    output logic [1:0]  o_fault_code,
    output logic        o_ramp_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RAMP  = 3'd1,
        S_RUN   = 3'd2,
        S_STOP  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [31:0] P_START = 32'(PERIOD_START);
    localparam logic [31:0] P_MIN   = 32'(PERIOD_MIN);
    localparam logic [31:0] P_STEP  = 32'(PERIOD_STEP);
    localparam logic [31:0] DIV_M1  = 32'(STEP_DIV - 1);

    state_t      state_q, state_d;
    logic [31:0] period_q, period_d;
    logic [31:0] cnt_q, cnt_d;
    logic        bridge_en_q, bridge_en_d;
    logic        fault_q, fault_d;
    logic [1:0]  fault_code_q, fault_code_d;
    logic        ramp_done_q, ramp_done_d;

    logic [31:0] target;
    logic [1:0]  new_bits;
    logic [1:0]  code_acc;
    logic        tick;
    logic        go_off;
    logic [31:0] nxt_period;

    // One rate-limited step from cur toward tgt; lands exactly when close enough.
    function automatic logic [31:0] step_toward(input logic [31:0] cur, input logic [31:0] tgt);
        logic [31:0] r;
        if (cur > tgt) begin
            r = ((cur - tgt) <= P_STEP) ? tgt : (cur - P_STEP);
        end else if (cur < tgt) begin
            r = ((tgt - cur) <= P_STEP) ? tgt : (cur + P_STEP);
        end else begin
            r = cur;
        end
        return r;
    endfunction

    always_comb begin
        if (i_target_period < P_MIN) begin
            target = P_MIN;
        end else if (i_target_period > P_START) begin
            target = P_START;
        end else begin
            target = i_target_period;
        end
    end

    assign new_bits = {i_sample_valid && (i_ibat > OC_LIMIT),
                       i_sample_valid && (i_vbat > OV_LIMIT)};
    assign code_acc = fault_code_q | new_bits;
    assign tick     = (cnt_q == DIV_M1);

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        bridge_en_d  = bridge_en_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        ramp_done_d  = ramp_done_q;
        go_off       = 1'b0;
        nxt_period   = period_q;

        case (state_q)
            S_IDLE: begin
                period_d = P_START;
                if (i_enable) begin
                    state_d     = S_RAMP;
                    bridge_en_d = 1'b1;
                end
            end
            S_RAMP: begin
                if (!i_enable) begin
                    go_off = 1'b1;
                end else begin
                    nxt_period = tick ? step_toward(period_q, target) : period_q;
                    period_d   = nxt_period;
                    if (nxt_period == target) begin
                        state_d     = S_RUN;
                        ramp_done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!i_enable) begin
                    go_off = 1'b1;
                end else if (target != period_q) begin
                    state_d     = S_RAMP;
                    ramp_done_d = 1'b0;
                end
            end
`ifdef BRIDGE_SOFT_STOP_EN
            S_STOP: begin
                if (i_enable) begin
                    state_d = S_RAMP;
                end else if (tick) begin
                    nxt_period = step_toward(period_q, P_START);
                    period_d   = nxt_period;
                    if (nxt_period == P_START) begin
                        state_d     = S_IDLE;
                        bridge_en_d = 1'b0;
                    end
                end
            end
`endif
            S_FAULT: begin
                fault_code_d = code_acc;
                // A fresh trip in the same cycle as the acknowledge keeps the fault latched.
                if (i_fault_clear && !i_enable && (new_bits == 2'b00)) begin
                    state_d      = S_IDLE;
                    fault_d      = 1'b0;
                    fault_code_d = 2'b00;
                end
            end
            default: begin
                state_d     = S_IDLE;
                period_d    = P_START;
                bridge_en_d = 1'b0;
                ramp_done_d = 1'b0;
            end
        endcase

        if (go_off) begin
            ramp_done_d = 1'b0;
`ifdef BRIDGE_SOFT_STOP_EN
            state_d     = S_STOP;
`else
            state_d     = S_IDLE;
            bridge_en_d = 1'b0;
            period_d    = P_START;
`endif
        end

        // Fault entry overrides every other decision made this cycle.
        if ((state_q != S_FAULT) && (code_acc != 2'b00)) begin
            state_d      = S_FAULT;
            bridge_en_d  = 1'b0;
            period_d     = P_START;
            ramp_done_d  = 1'b0;
            fault_d      = 1'b1;
            fault_code_d = code_acc;
        end

        if ((state_d != state_q) || tick) begin
            cnt_d = 32'd0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            period_q     <= P_START;
            cnt_q        <= 32'd0;
            bridge_en_q  <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
            ramp_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            cnt_q        <= cnt_d;
            bridge_en_q  <= bridge_en_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            ramp_done_q  <= ramp_done_d;
        end
    end

    assign o_state      = state_q;
    assign o_period     = period_q;
    assign o_bridge_en  = bridge_en_q;
    assign o_fault      = fault_q;
    assign o_fault_code = fault_code_q;
    assign o_ramp_done  = ramp_done_q;

endmodule

// File: tb/tb_bridge_softstart_sequencer.sv
// Bench for bridge_softstart_sequencer (default build, soft stop disabled).
// The expected half-period is derived in closed form: steps taken = floor(cycles since RAMP entry / STEP_DIV).
module tb_bridge_softstart_sequencer;
    localparam int PS   = 20;
    localparam int PM   = 5;
    localparam int STEP = 2;
    localparam int DIV  = 4;

    logic        clk = 1'b0;
    logic        rst, en, clr, sv;
    logic [31:0] tgt;
    logic [7:0]  vb, ib;
    logic [31:0] period;
    logic        bridge_en, fault, done;
    logic [2:0]  state;
    logic [1:0]  code;

    int n_checks = 0;
    int n_fail   = 0;
    int model_period = PS;

    always #5 clk = ~clk;

    bridge_softstart_sequencer #(
        .PERIOD_START(PS), .PERIOD_MIN(PM), .PERIOD_STEP(STEP), .STEP_DIV(DIV),
        .OV_LIMIT(8'd100), .OC_LIMIT(8'd120)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_target_period(tgt),
        .i_vbat(vb), .i_ibat(ib), .i_sample_valid(sv), .i_fault_clear(clr),
        .o_period(period), .o_bridge_en(bridge_en), .o_state(state),
        .o_fault(fault), .o_fault_code(code), .o_ramp_done(done)
    );

    function automatic int eff_target(input int raw);
        if (raw < PM) return PM;
        if (raw > PS) return PS;
        return raw;
    endfunction

    function automatic int expect_period(input int start, input int eff, input int k);
        int moved;
        moved = (k / DIV) * STEP;
        if (start > eff) return (start - moved < eff) ? eff : start - moved;
        return (start + moved > eff) ? eff : start + moved;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // The caller has already applied the stimulus that starts a ramp; the next edge is the RAMP entry.
    task automatic ramp_track(input int start_p, input int eff);
        int  exp_p;
        bit  landed;
        landed = 1'b0;
        step();
        n_checks++;
        if (state !== 3'd1 || period !== 32'(start_p) || bridge_en !== 1'b1) begin
            n_fail++;
            $display("FAIL ramp_entry: state=%0d period=%0d en=%b, required state=1 period=%0d en=1",
                     state, period, bridge_en, start_p);
        end
        for (int k = 1; k <= 200 && !landed; k++) begin
            step();
            exp_p = expect_period(start_p, eff, k);
            landed = (exp_p == eff);
            n_checks++;
            if (period !== 32'(exp_p)) begin
                n_fail++;
                $display("FAIL ramp_period k=%0d: got %0d, required %0d", k, period, exp_p);
            end
            n_checks++;
            if (state !== (landed ? 3'd2 : 3'd1) || done !== landed) begin
                n_fail++;
                $display("FAIL ramp_state k=%0d: state=%0d done=%b, required state=%0d done=%b",
                         k, state, done, landed ? 2 : 1, landed);
            end
        end
        if (!landed) begin
            n_fail++;
            $display("FAIL ramp_timeout: target %0d not reached", eff);
        end
        model_period = eff;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; sv = 1'b0; tgt = 32'd10; vb = 8'd0; ib = 8'd0;
        step();
        step();
        rst = 1'b0;
        n_checks++;
        if (state !== 3'd0 || period !== 32'(PS) || bridge_en !== 1'b0 ||
            fault !== 1'b0 || code !== 2'b00 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: state=%0d period=%0d en=%b fault=%b code=%b done=%b, required 0 %0d 0 0 00 0",
                     state, period, bridge_en, fault, code, done, PS);
        end
        model_period = PS;
    endtask

    task automatic test_ramp_basic();
        tgt = 32'd10;
        en  = 1'b1;
        ramp_track(PS, 10);
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (state !== 3'd2 || period !== 32'd10 || done !== 1'b1) begin
                n_fail++;
                $display("FAIL run_hold: state=%0d period=%0d done=%b, required 2 10 1", state, period, done);
            end
        end
    endtask

    task automatic test_retarget();
        tgt = 32'd11;
        ramp_track(10, 11);
        tgt = 32'd3;
        ramp_track(11, eff_target(3));
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if (state !== 3'd2 || period !== 32'(PM)) begin
                n_fail++;
                $display("FAIL clamp_floor: state=%0d period=%0d, required 2 %0d", state, period, PM);
            end
        end
    endtask

    task automatic test_random_ramps();
        int raw, e;
        for (int it = 0; it < 6; it++) begin
            raw = int'($urandom_range(0, 30));
            e   = eff_target(raw);
            tgt = 32'(raw);
            if (e == model_period) begin
                repeat (5) step();
                n_checks++;
                if (state !== 3'd2 || period !== 32'(e)) begin
                    n_fail++;
                    $display("FAIL random_hold raw=%0d: state=%0d period=%0d, required 2 %0d", raw, state, period, e);
                end
            end else begin
                ramp_track(model_period, e);
            end
        end
    endtask

    task automatic test_disable();
        tgt = 32'd10;
        if (model_period != 10) ramp_track(model_period, 10);
        en = 1'b0;
        step();
        n_checks++;
        if (state !== 3'd0 || period !== 32'(PS) || bridge_en !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_run: state=%0d period=%0d en=%b done=%b, required 0 %0d 0 0",
                     state, period, bridge_en, done, PS);
        end
        model_period = PS;
    endtask

    task automatic test_reset_midramp();
        tgt = 32'd10;
        en  = 1'b1;
        step();
        repeat (12) step();
        n_checks++;
        if (period !== 32'd14 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL midramp_pre: period=%0d state=%0d, required 14 1", period, state);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (state !== 3'd0 || period !== 32'(PS) || bridge_en !== 1'b0 ||
            fault !== 1'b0 || code !== 2'b00 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midramp_reset: state=%0d period=%0d en=%b fault=%b code=%b done=%b",
                     state, period, bridge_en, fault, code, done);
        end
        en  = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_fault();
        tgt = 32'd10;
        en  = 1'b1;
        step();
        repeat (5) step();
        sv = 1'b1; vb = 8'd101; ib = 8'd121;
        step();
        sv = 1'b0;
        n_checks++;
        if (state !== 3'd4 || bridge_en !== 1'b0 || code !== 2'b11 || period !== 32'(PS) ||
            fault !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_entry: state=%0d en=%b code=%b period=%0d fault=%b done=%b",
                     state, bridge_en, code, period, fault, done);
        end
        clr = 1'b1;
        repeat (3) step();
        n_checks++;
        if (state !== 3'd4 || fault !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_while_enabled: state=%0d fault=%b, required 4 1", state, fault);
        end
        en = 1'b0;
        step();
        clr = 1'b0;
        n_checks++;
        if (state !== 3'd0 || fault !== 1'b0 || code !== 2'b00) begin
            n_fail++;
            $display("FAIL fault_clear: state=%0d fault=%b code=%b, required 0 0 00", state, fault, code);
        end
        sv = 1'b1; vb = 8'd101; ib = 8'd0;
        step();
        sv = 1'b0;
        n_checks++;
        if (state !== 3'd4 || code !== 2'b01) begin
            n_fail++;
            $display("FAIL fault_ov_only: state=%0d code=%b, required 4 01", state, code);
        end
        step();
        sv = 1'b1; vb = 8'd0; ib = 8'd121;
        step();
        sv = 1'b0;
        n_checks++;
        if (state !== 3'd4 || code !== 2'b11) begin
            n_fail++;
            $display("FAIL fault_accumulate: state=%0d code=%b, required 4 11", state, code);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        en  = 1'b1;
        step();
        en = 1'b0; sv = 1'b1; vb = 8'd101; ib = 8'd0;
        step();
        sv = 1'b0;
        n_checks++;
        if (state !== 3'd4 || bridge_en !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_priority: state=%0d en=%b, required 4 0", state, bridge_en);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_sample_gate();
        logic [7:0] v, c;
        logic       s;
        logic [1:0] exp_code;
        en = 1'b0;
        for (int it = 0; it < 20; it++) begin
            case (it)
                0: begin v = 8'd101; c = 8'd0;   s = 1'b0; end
                1: begin v = 8'd100; c = 8'd120; s = 1'b1; end
                2: begin v = 8'd101; c = 8'd121; s = 1'b0; end
                3: begin v = 8'd255; c = 8'd255; s = 1'b0; end
                default: begin
                    v = 8'($urandom_range(80, 130));
                    c = 8'($urandom_range(100, 140));
                    s = 1'($urandom_range(0, 1));
                end
            endcase
            exp_code = s ? {c > 8'd120, v > 8'd100} : 2'b00;
            vb = v; ib = c; sv = s;
            step();
            sv = 1'b0;
            n_checks++;
            if (code !== exp_code || state !== ((exp_code != 2'b00) ? 3'd4 : 3'd0)) begin
                n_fail++;
                $display("FAIL sample_gate v=%0d i=%0d valid=%b: code=%b state=%0d, required code=%b",
                         v, c, s, code, state, exp_code);
            end
            if (exp_code != 2'b00) begin
                clr = 1'b1;
                step();
                clr = 1'b0;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ramp_basic();
        test_retarget();
        test_random_ramps();
        test_disable();
        test_reset_midramp();
        test_fault();
        test_sample_gate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bridge_softstart_sequencer.md
BRIDGE_SOFTSTART_SEQUENCER -- requirements
Module: bridge_softstart_sequencer

Interface
REQ-001 SHALL have parameter PERIOD_START, default 500, bridge half-period in clock cycles used at start and idle.
REQ-002 SHALL have parameter PERIOD_MIN, default 50, lowest allowed half-period, which is the highest frequency.
REQ-003 SHALL have parameter PERIOD_STEP, default 1, maximum half-period change per ramp tick.
REQ-004 SHALL have parameter STEP_DIV, default 100000, clock cycles per ramp tick (1 ms at 100 MHz).
REQ-005 SHALL have parameters OV_LIMIT, default 8'd160, and OC_LIMIT, default 8'd200, as 8-bit raw rectifier ADC trip levels.
REQ-006 SHALL have port i_clock  in  1  100 MHz system clock; one clock domain only.
REQ-007 SHALL have port i_reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port i_enable  in  1  debounced converter enable.
REQ-009 SHALL have port i_target_period  in  32  requested half-period, unsigned.
REQ-010 SHALL have ports i_vbat and i_ibat  in  8  latest rectifier ADC samples.
REQ-011 SHALL have port i_sample_valid  in  1  one-cycle pulse indicating i_vbat and i_ibat are new.
REQ-012 SHALL have port i_fault_clear  in  1  fault acknowledge.
REQ-013 SHALL have port o_period  out  32  half-period driven to the square-wave counter.
REQ-014 SHALL have port o_bridge_en  out  1  H-bridge gate enable.
REQ-015 SHALL have ports o_state  out  3, o_fault  out  1, o_fault_code  out  2 (bit0 = OV, bit1 = OC), and o_ramp_done  out  1.

Function
REQ-016 SHALL use states IDLE=0, RAMP=1, RUN=2, STOP=3, FAULT=4, with o_state equal to the state register and all outputs registered.
REQ-017 SHALL compute the effective target as i_target_period clamped to [PERIOD_MIN, PERIOD_START], re-evaluated every cycle.
REQ-018 SHALL move from IDLE to RAMP when i_enable=1 and no fault is latched, asserting o_bridge_en on that same transition edge.
REQ-019 SHALL restart the tick counter at 0 on every state entry and pulse a tick after it reaches STEP_DIV-1.
REQ-020 SHALL, in RAMP on each tick, move o_period toward the target by PERIOD_STEP, landing exactly on the target when the remaining distance is at most PERIOD_STEP, and SHALL never overshoot or underflow.
REQ-021 SHALL enter RUN and set o_ramp_done=1 on the edge where o_period equals the target.
REQ-022 SHALL, in RUN, return to RAMP and clear o_ramp_done when the target differs from o_period; this rate-limits changes in both directions.
REQ-023 SHALL, on a cycle with i_sample_valid=1, set bit0 of the fault code when i_vbat>OV_LIMIT and bit1 when i_ibat>OC_LIMIT; the comparison is strict.
REQ-024 SHALL, when any fault bit is set, on the next edge from any state enter FAULT, drive o_bridge_en=0, o_period=PERIOD_START, o_ramp_done=0 and o_fault=1.
REQ-025 SHALL give the fault transition priority over enable changes and ticks arriving in the same cycle.
REQ-026 SHALL leave FAULT for IDLE, clearing o_fault and o_fault_code, only when i_fault_clear=1 and i_enable=0, and SHALL ignore i_fault_clear while i_enable=1.
REQ-027 SHALL OR further fault bits into o_fault_code while in FAULT.
REQ-028 SHALL ignore i_sample_valid when it is 0, regardless of i_vbat and i_ibat.

Reset
REQ-029 SHALL, with i_reset=1 at a clock edge, set the state to IDLE, o_period=PERIOD_START, o_bridge_en=0, o_fault=0, o_fault_code=0, o_ramp_done=0 and the tick counter to 0, including mid-ramp and mid-fault.

Configuration
REQ-030 SHALL compile in soft stop with macro BRIDGE_SOFT_STOP_EN. When defined, i_enable=0 in RAMP or RUN enters STOP, which keeps o_bridge_en=1 and raises o_period by PERIOD_STEP per tick up to PERIOD_START, then goes to IDLE. i_enable=1 during STOP returns to RAMP from the current o_period. When undefined, i_enable=0 in RAMP or RUN goes to IDLE on the next edge with o_bridge_en=0 and o_period=PERIOD_START, and STOP is unreachable.

Verification (bench parameters: PERIOD_START=20, PERIOD_MIN=5, PERIOD_STEP=2, STEP_DIV=4, OV_LIMIT=100, OC_LIMIT=120)
REQ-031 SHALL cover enable=1 with target=10: o_period steps 20,18,16,14,12,10, one step per 4 cycles; then RUN with o_ramp_done=1.
REQ-032 SHALL cover target=11, then target=3: o_period stops exactly at 11; the clamped target then ramps it down to 5 and never below.
REQ-033 SHALL cover i_sample_valid with i_vbat=101 and i_ibat=121 during RAMP: next edge FAULT, o_bridge_en=0, o_fault_code=2'b11, o_period=20; clear with enable=1 keeps FAULT; clear with enable=0 goes to IDLE.
REQ-034 SHALL cover i_vbat=101 with i_sample_valid=0: no fault raised.
REQ-035 SHALL cover enable=0 in RUN at period 10: without the macro, IDLE next edge with period 20; with the macro, STOP stepping 12,14..20 every 4 cycles, then IDLE and o_bridge_en=0.
REQ-036 SHALL cover i_reset=1 for one cycle mid-ramp at period 14: all outputs return to their reset values on that edge.
